four_bank_responder: RTL and testbench



---
 rtl/four_bank_responder.sv | 115 +++++++++++
 tb/tb_four_bank_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/four_bank_responder.sv
// four_bank_responder
//
// Memory-side responder for the cache-to-memory request interface. Single-word
// read/write requests are spread across four word-interleaved banks. Each access
// keeps its bank busy for four cycles, and read data comes back exactly two
// cycles after the request is accepted.
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   rst_n     asynchronous active-low reset
//   addr      byte address; addr[2:1] selects the bank, addr[0] must be 0
//   data_in   write data, sampled together with wr
//   rd, wr    read / write request (exactly one may be high)
//   data_out  read data; zero whenever rd_valid is low
//   rd_valid  one-cycle pulse marking data_out valid
//   stall     combinational; request not accepted this cycle and must be held
//   busy      per-bank busy flags, bit b = bank b
//   err       one-cycle registered pulse flagging an illegal request
module four_bank_responder #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] data_out,
    output logic        rd_valid,
    output logic        stall,
    output logic [3:0]  busy,
    output logic        err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [15:0]           mem [4][DEPTH];
    logic [1:0]            cnt [4];
    logic [1:0]            bank;
    logic [DEPTH_LOG2-1:0] slot;
    logic                  legal;
    logic                  accept;
    logic                  s1_valid;
    logic [15:0]           s1_data;
    logic                  s2_valid;
    logic [15:0]           s2_data;
    logic                  err_q;
    logic                  unused_addr_bits;

    assign bank  = addr[2:1];
    assign slot  = addr[DEPTH_LOG2+2:3];
    // Upper address bits simply alias onto the same slots.
    assign unused_addr_bits = ^addr[15:DEPTH_LOG2+3];

    // Stall depends only on the target bank being busy, not on legality, so an
    // illegal request to a busy bank is held rather than flagged.
    assign legal  = (rd ^ wr) & ~addr[0];
    assign stall  = (rd | wr) & busy[bank];
    assign accept = legal & ~stall;

    always_comb begin
        busy = '0;
        for (int b = 0; b < 4; b++) begin
            busy[b] = (cnt[b] != 2'd0);
        end
    end

    // Per-bank occupancy counters. A reload can only happen at zero because a
    // busy bank stalls every request aimed at it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 4; b++) begin
                cnt[b] <= 2'd0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (accept && (bank == b[1:0])) begin
                    cnt[b] <= 2'd3;
                end else if (cnt[b] != 2'd0) begin
                    cnt[b] <= cnt[b] - 2'd1;
                end
            end
        end
    end

    // Bank arrays are deliberately not reset.
    always_ff @(posedge clk) begin
        if (accept && wr) begin
            mem[bank][slot] <= data_in;
        end
    end

    // Two-stage read pipeline carrying the data itself, so later writes to the
    // same slot cannot disturb a read that is already in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            err_q    <= 1'b0;
        end else begin
            s1_valid <= accept & rd;
            s1_data  <= mem[bank][slot];
            s2_valid <= s1_valid;
            s2_data  <= s1_data;
            err_q    <= (rd | wr) & ~legal & ~stall;
        end
    end

    assign rd_valid = s2_valid;
    assign data_out = s2_valid ? s2_data : 16'h0000;
    assign err      = err_q;

endmodule

// File: tb/tb_four_bank_responder.sv
// tb_four_bank_responder
//
// Directed bench for four_bank_responder. Requests are driven cycle by cycle
// with hand-computed stall/busy/err expectations; expected read data is queued
// with its due cycle and a separate monitor matches it against rd_valid pulses.
module tb_four_bank_responder;

    logic        clk;
    logic        rst_n;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        rd;
    logic        wr;
    logic [15:0] data_out;
    logic        rd_valid;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    four_bank_responder #(.DEPTH_LOG2(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .data_in  (data_in),
        .rd       (rd),
        .wr       (wr),
        .data_out (data_out),
        .rd_valid (rd_valid),
        .stall    (stall),
        .busy     (busy),
        .err      (err)
    );

    // 10-unit clock; cycle index advances on each rising edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one request for one cycle, check this cycle's stall/busy/err at the
    // falling edge, and queue expected read data if the read should return.
    task automatic applyStimulus(input logic r, input logic w, input logic [15:0] a,
                                 input logic [15:0] d, input logic exp_stall,
                                 input logic [3:0] exp_busy, input logic exp_err,
                                 input logic push_rd, input logic [15:0] exp_rd);
        exp_t e;
        rd      = r;
        wr      = w;
        addr    = a;
        data_in = d;
        @(negedge clk);
        checkOutput("stall", {15'd0, stall}, {15'd0, exp_stall});
        checkOutput("busy", {12'd0, busy}, {12'd0, exp_busy});
        checkOutput("err", {15'd0, err}, {15'd0, exp_err});
        if (push_rd) begin
            e.data = exp_rd;
            e.due  = cyc + 2;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [3:0] exp_busy, input logic exp_err);
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, exp_busy, exp_err, 1'b0, 16'h0000);
    endtask

    // Monitor: every rd_valid pulse must match the oldest queued read, arriving
    // in exactly its due cycle; data_out must be zero outside pulses.
    always @(negedge clk) begin
        exp_t e;
        if (rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_rd_valid", {15'd0, rd_valid}, 16'h0000);
            end else begin
                e = sb.pop_front();
                checkOutput("rd_data", data_out, e.data);
                checkOutput("rd_latency_cycle", cyc[15:0], e.due[15:0]);
            end
        end else begin
            checkOutput("data_out_idle", data_out, 16'h0000);
        end
        if (sb.size() != 0 && sb[0].due < cyc) begin
            checkOutput("missing_rd_valid", {15'd0, rd_valid}, 16'h0001);
            void'(sb.pop_front());
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        rd      = 1'b0;
        wr      = 1'b0;
        addr    = '0;
        data_in = '0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", {12'd0, busy}, 16'h0000);
        checkOutput("reset_stall", {15'd0, stall}, 16'h0000);
        checkOutput("reset_err", {15'd0, err}, 16'h0000);
        checkOutput("reset_rd_valid", {15'd0, rd_valid}, 16'h0000);
        @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] write BEEF to bank 0 then read it back at cycle 4");
        applyStimulus(1'b0, 1'b1, 16'h0008, 16'hBEEF, 1'b0, 4'b0000, 1'b0, 1'b0, 16'h0000);
        idle(4'b0001, 1'b0);
        idle(4'b0001, 1'b0);
        idle(4'b0001, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0008, 16'h0000, 1'b0, 4'b0000, 1'b0, 1'b1, 16'hBEEF);
        idle(4'b0001, 1'b0);
        idle(4'b0001, 1'b0);
        idle(4'b0001, 1'b0);
        idle(4'b0000, 1'b0);

        $display("[TB] same-bank conflict on bank 1");
        applyStimulus(1'b0, 1'b1, 16'h0002, 16'h1234, 1'b0, 4'b0000, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b1, 4'b0010, 1'b0, 1'b0, 16'h0000);
        end
        applyStimulus(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, 4'b0000, 1'b0, 1'b1, 16'h1234);
        idle(4'b0010, 1'b0);
        idle(4'b0010, 1'b0);
        idle(4'b0010, 1'b0);
        idle(4'b0000, 1'b0);

        $display("[TB] interleaved line write then back-to-back reads");
        applyStimulus(1'b0, 1'b1, 16'h0010, 16'h1111, 1'b0, 4'b0000, 1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b1, 16'h0012, 16'h2222, 1'b0, 4'b0001, 1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b1, 16'h0014, 16'h3333, 1'b0, 4'b0011, 1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b1, 16'h0016, 16'h4444, 1'b0, 4'b0111, 1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 4'b1110, 1'b0, 1'b1, 16'h1111);
        applyStimulus(1'b1, 1'b0, 16'h0012, 16'h0000, 1'b0, 4'b1101, 1'b0, 1'b1, 16'h2222);
        applyStimulus(1'b1, 1'b0, 16'h0014, 16'h0000, 1'b0, 4'b1011, 1'b0, 1'b1, 16'h3333);
        applyStimulus(1'b1, 1'b0, 16'h0016, 16'h0000, 1'b0, 4'b0111, 1'b0, 1'b1, 16'h4444);
        idle(4'b1110, 1'b0);
        idle(4'b1100, 1'b0);
        idle(4'b1000, 1'b0);
        idle(4'b0000, 1'b0);

        $display("[TB] illegal requests leave banks and memory alone");
        applyStimulus(1'b0, 1'b1, 16'h0000, 16'h5555, 1'b0, 4'b0000, 1'b0, 1'b0, 16'h0000);
        idle(4'b0001, 1'b0);
        idle(4'b0001, 1'b0);
        idle(4'b0001, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h0000, 16'hDEAD, 1'b0, 4'b0000, 1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b0, 16'h0001, 16'h0000, 1'b0, 4'b0000, 1'b1, 1'b0, 16'h0000);
        idle(4'b0000, 1'b1);
        idle(4'b0000, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b0, 1'b1, 16'h5555);
        idle(4'b0001, 1'b0);
        idle(4'b0001, 1'b0);
        idle(4'b0001, 1'b0);
        idle(4'b0000, 1'b0);

        $display("[TB] reset while a read is in flight");
        applyStimulus(1'b1, 1'b0, 16'h0008, 16'h0000, 1'b0, 4'b0000, 1'b0, 1'b0, 16'h0000);
        rst_n = 1'b0;
        idle(4'b0000, 1'b0);
        idle(4'b0000, 1'b0);
        idle(4'b0000, 1'b0);
        rst_n = 1'b1;
        idle(4'b0000, 1'b0);

        $display("[TB] address aliasing above the slot field");
        applyStimulus(1'b0, 1'b1, 16'h0000, 16'hA5A5, 1'b0, 4'b0000, 1'b0, 1'b0, 16'h0000);
        idle(4'b0001, 1'b0);
        idle(4'b0001, 1'b0);
        idle(4'b0001, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0200, 16'h0000, 1'b0, 4'b0000, 1'b0, 1'b1, 16'hA5A5);
        idle(4'b0001, 1'b0);
        idle(4'b0001, 1'b0);
        idle(4'b0001, 1'b0);
        idle(4'b0000, 1'b0);
        idle(4'b0000, 1'b0);

        checkOutput("scoreboard_drained", sb.size() > 0 ? 16'h0001 : 16'h0000, 16'h0000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
